// File: rtl/ir_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the IR pulse-width frame decoder.
//   ir_state_t      : decoder state encoding (IDLE, LEADER, DATA, DONE)
//   IR_LEAD_MIN     : default leader threshold (high ticks, strictly greater)
//   IR_ONE_MIN      : default '1' threshold (high ticks, strictly greater)
//   IR_GAP_MAX      : default in-frame low timeout (ticks, strictly greater)
//   inv_bytes_ok()  : checks byte1 == ~byte0 and byte3 == ~byte2 of a word
// ---------------------------------------------------------------------------
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEADER = 2'd1,
      DATA   = 2'd2,
      DONE   = 2'd3
   } ir_state_t;

   localparam int IR_LEAD_MIN = 15;
   localparam int IR_ONE_MIN  = 10;
   localparam int IR_GAP_MAX  = 8;

   function automatic logic inv_bytes_ok(input logic [31:0] w);
      return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
   endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ---------------------------------------------------------------------------
// ir_pulse_timer
// Saturating duration counter, advanced by the sample tick.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   clr   : clear to zero (wins over counting)
//   en    : count enable (line is at the level being timed)
//   tick  : sample enable
//   cnt   : current duration, holds at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module ir_pulse_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             tick,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && tick && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ir_frame_decoder.sv
// ---------------------------------------------------------------------------
// ir_frame_decoder
// Pulse-width IR frame decoder: times high/low durations of the demodulated
// line, detects a leader pulse, then captures NBITS bits (long high = 1,
// short high = 0), LSB first. Aborts on an in-frame gap or a re-leader.
// Optional build macro: IR_INV_CHECK_EN (only acts when NBITS == 32) rejects
// frames whose byte1/byte3 are not the inverse of byte0/byte2.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   tick       : sample enable for the duration counters
//   ir_in      : demodulated IR line (asynchronous)
//   data_out   : last accepted frame, LSB = first received bit
//   data_valid : one-cycle pulse when data_out updates
//   busy       : high while in LEADER or DATA
//   frame_err  : one-cycle pulse on abort
//   bit_cnt    : bits captured in the current frame
// ---------------------------------------------------------------------------
module ir_frame_decoder
   import ir_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int NBITS    = 32,
   parameter int LEAD_MIN = IR_LEAD_MIN,
   parameter int ONE_MIN  = IR_ONE_MIN,
   parameter int GAP_MAX  = IR_GAP_MAX
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tick,
   input  logic                       ir_in,
   output logic [NBITS-1:0]           data_out,
   output logic                       data_valid,
   output logic                       busy,
   output logic                       frame_err,
   output logic [$clog2(NBITS+1)-1:0] bit_cnt
);

   localparam int BC_W = $clog2(NBITS+1);
   localparam logic [CNT_W-1:0] LEAD_TH = CNT_W'(LEAD_MIN);
   localparam logic [CNT_W-1:0] ONE_TH  = CNT_W'(ONE_MIN);
   localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(GAP_MAX);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(NBITS-1);

`ifdef IR_INV_CHECK_EN
   localparam bit INV_CHK = (NBITS == 32);
`else
   localparam bit INV_CHK = 1'b0;
`endif

   ir_state_t        state;
   logic             ir_m, ir_s, ir_p;
   logic             rise, fall;
   logic [CNT_W-1:0] hi_cnt, lo_cnt;
   logic [NBITS-1:0] shreg;
   logic             gap;

   // Two-flop synchroniser plus one delay flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_m <= 1'b0;
         ir_s <= 1'b0;
         ir_p <= 1'b0;
      end else begin
         ir_m <= ir_in;
         ir_s <= ir_m;
         ir_p <= ir_s;
      end
   end

   assign rise = ir_s & ~ir_p;
   assign fall = ~ir_s & ir_p;
   assign gap  = ~ir_s && (lo_cnt > GAP_TH);

   ir_pulse_timer #(.CNT_W(CNT_W)) u_hi (
      .clk(clk), .reset(reset), .clr(rise), .en(ir_s), .tick(tick), .cnt(hi_cnt)
   );

   ir_pulse_timer #(.CNT_W(CNT_W)) u_lo (
      .clk(clk), .reset(reset), .clr(fall), .en(~ir_s), .tick(tick), .cnt(lo_cnt)
   );

   // Frame FSM; decisions use the counter values present at the edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= '0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (fall && (hi_cnt > LEAD_TH)) begin
                  state <= LEADER;
                  busy  <= 1'b1;
               end
            end
            LEADER: begin
               if (rise) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end else if (gap) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  frame_err <= 1'b1;
               end
            end
            DATA: begin
               if (fall) begin
                  if (hi_cnt > LEAD_TH) begin
                     // A leader-length pulse mid-frame restarts the frame
                     state     <= LEADER;
                     bit_cnt   <= '0;
                     frame_err <= 1'b1;
                  end else begin
                     for (int i = 0; i < NBITS; i++) begin
                        if (bit_cnt == BC_W'(i)) shreg[i] <= (hi_cnt > ONE_TH);
                     end
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                     end
                  end
               end else if (gap) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  bit_cnt   <= '0;
                  frame_err <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               if (INV_CHK && !inv_bytes_ok(32'(shreg))) begin
                  frame_err <= 1'b1;
               end else begin
                  data_out   <= shreg;
                  data_valid <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
